// File: rtl/keypad_emulator.sv
// Passive 4x4 keypad model: answers the scanner's row drive with one commanded key.
// Define KEYPAD_BOUNCE_EN for LFSR-driven contact bounce during the press and release windows.
module keypad_emulator #(
    parameter int TICK_CYCLES   = 50000,
    parameter int BOUNCE_CYCLES = 250000,
    parameter int HOLD_W        = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              press_valid,
    output logic              press_ready,
    input  logic [3:0]        press_key,
    input  logic [HOLD_W-1:0] press_hold,
    input  logic [3:0]        keypadRow,
    output logic [3:0]        keypadCol,
    output logic              busy,
    output logic              done
);

    localparam int MAXC = (TICK_CYCLES > BOUNCE_CYCLES) ? TICK_CYCLES : BOUNCE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DN_LAST   = CW'(BOUNCE_CYCLES);
    localparam logic [CW-1:0] UP_LAST   = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BOUNCE_DN, HELD, BOUNCE_UP} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cyc, cyc_nxt;
    logic [HOLD_W-1:0] tick, tick_nxt;
    logic [3:0]        key_r;
    logic [HOLD_W-1:0] hold_r;
    logic              contact, contact_nxt;
    logic              done_nxt;
    logic              accept;
    logic              noise;

`ifdef KEYPAD_BOUNCE_EN
    logic [15:0] lfsr;

    // Free-running so the bounce pattern depends only on time since reset
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign noise = lfsr[0];
`else
    assign noise = 1'b0;
`endif

    assign accept = press_valid && press_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cyc     <= '0;
            tick    <= '0;
            contact <= 1'b0;
            done    <= 1'b0;
            key_r   <= '0;
            hold_r  <= '0;
        end else begin
            state   <= state_nxt;
            cyc     <= cyc_nxt;
            tick    <= tick_nxt;
            contact <= contact_nxt;
            done    <= done_nxt;
            if (accept) begin
                key_r  <= press_key;
                hold_r <= (press_hold == '0) ? HOLD_W'(1) : press_hold;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc + 1'b1;
        tick_nxt  = tick;
        unique case (state)
            IDLE: begin
                cyc_nxt  = '0;
                tick_nxt = '0;
                if (accept) state_nxt = BOUNCE_DN;
            end
            BOUNCE_DN: begin
                if (cyc == DN_LAST) begin
                    state_nxt = HELD;
                    cyc_nxt   = '0;
                end
            end
            HELD: begin
                if (cyc == TICK_LAST) begin
                    cyc_nxt = '0;
                    if (tick == hold_r - 1'b1) begin
                        state_nxt = BOUNCE_UP;
                        tick_nxt  = '0;
                    end else begin
                        tick_nxt = tick + 1'b1;
                    end
                end
            end
            BOUNCE_UP: begin
                if (cyc == UP_LAST) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                end
            end
        endcase
    end

    always_comb begin
        contact_nxt = 1'b0;
        done_nxt    = (state == BOUNCE_UP) && (state_nxt == IDLE);
        unique case (state_nxt)
            IDLE:      contact_nxt = 1'b0;
            HELD:      contact_nxt = 1'b1;
`ifdef KEYPAD_BOUNCE_EN
            BOUNCE_DN: contact_nxt = (cyc_nxt == DN_LAST) ? 1'b1 : noise;
            BOUNCE_UP: contact_nxt = (cyc_nxt == UP_LAST) ? 1'b0 : noise;
`else
            BOUNCE_DN: contact_nxt = noise;
            BOUNCE_UP: contact_nxt = 1'b1;
`endif
        endcase
    end

    assign press_ready = (state == IDLE);
    assign busy        = !press_ready;

    // A row line that is not a clean 0 leaves the column released
    always_comb begin
        keypadCol = 4'b1111;
        if (contact && keypadRow[key_r[3:2]] == 1'b0)
            keypadCol[key_r[1:0]] = 1'b0;
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator with short tick and bounce windows.
// Covers reset, table-driven presses with row scanning, reset mid-press and back-to-back presses.
module tb_keypad_emulator;

    localparam int T  = 4;
    localparam int B  = 3;
    localparam int HW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          press_valid = 1'b0;
    logic          press_ready;
    logic [3:0]    press_key = '0;
    logic [HW-1:0] press_hold = '0;
    logic [3:0]    keypadRow = 4'b1111;
    logic [3:0]    keypadCol;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    keypad_emulator #(
        .TICK_CYCLES(T),
        .BOUNCE_CYCLES(B),
        .HOLD_W(HW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .press_valid(press_valid),
        .press_ready(press_ready),
        .press_key(press_key),
        .press_hold(press_hold),
        .keypadRow(keypadRow),
        .keypadCol(keypadCol),
        .busy(busy),
        .done(done)
    );

    typedef struct {
        logic [3:0]    key;
        logic [HW-1:0] hold;
        int            eff;
        bit            stray;
    } vec_t;

    typedef struct {
        logic [3:0] col;
        logic       busy;
        logic       done;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    logic [3:0] rows [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] col_of(input logic [3:0] key, input logic [3:0] row,
                                          input bit contact);
        logic [3:0] c;
        c = 4'b1111;
        if (contact && row[key[3:2]] == 1'b0) c[key[1:0]] = 1'b0;
        return c;
    endfunction

    // Called at #1 after an accept edge; counts cycles until done is seen
    task automatic wait_done(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n, exp_lat);
    endtask

    task automatic run_press(input vec_t v);
        int   last;
        exp_t e;
        last = 2 * B + v.eff * T;
        press_key   = v.key;
        press_hold  = v.hold;
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        for (int k = 0; k <= last + 2; k++) begin
            keypadRow = rows[k % 5];
            if (v.stray && k >= B + 1 && k <= B + v.eff * T) begin
                press_valid = 1'b1;
                press_key   = ~v.key;
                press_hold  = HW'(7);
            end else begin
                press_valid = 1'b0;
            end
            e.col  = col_of(v.key, keypadRow, (k >= B + 1) && (k <= last));
            e.busy = (k <= last);
            e.done = (k == last + 1);
            sbq.push_back(e);
            #1;
            e = sbq.pop_front();
`ifdef KEYPAD_BOUNCE_EN
            if (!(k <= B || (k > B + v.eff * T && k <= last)))
`endif
            chk("col", keypadCol, e.col);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            @(posedge clk); #1;
        end
    endtask

`ifdef KEYPAD_BOUNCE_EN
    logic [3:0] rec0 [32];
    logic [3:0] rec1 [32];

    task automatic bounce_run(output logic [3:0] rec [32]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        keypadRow   = 4'b1101;
        press_key   = 4'b0101;
        press_hold  = HW'(1);
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rec[k] = keypadCol;
            if (k >= B + 1 && k <= B + T) chk("bounce_held", keypadCol, 4'b1101);
            if (k >= 2 * B + T + 1) chk("bounce_after", keypadCol, 4'b1111);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        vec_t vecs [4];
        vecs[0] = '{key: 4'b0110, hold: HW'(2), eff: 2, stray: 1'b0};
        vecs[1] = '{key: 4'b1111, hold: HW'(0), eff: 1, stray: 1'b0};
        vecs[2] = '{key: 4'b0000, hold: HW'(3), eff: 3, stray: 1'b0};
        vecs[3] = '{key: 4'b1001, hold: HW'(1), eff: 1, stray: 1'b1};

        repeat (2) @(posedge clk);
        #1;
        keypadRow = 4'b0000;
        #1;
        chk("rst_col", keypadCol, 4'b1111);
        chk("rst_ready", press_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_press(vecs[i]);

        // Reset in the middle of HELD
        keypadRow   = 4'b1101;
        press_key   = 4'b0110;
        press_hold  = HW'(2);
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        repeat (B + 3) @(posedge clk);
        #1;
        chk("held_col", keypadCol, 4'b1011);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_col", keypadCol, 4'b1111);
        chk("midrst_ready", press_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);

        // New press straight after reset, then a back-to-back press on done
        press_key   = 4'b0011;
        press_hold  = HW'(1);
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        chk("post_rst_busy", busy, 1'b1);
        wait_done("lat_after_rst", 2 * B + T + 1);
        chk("done_ready", press_ready, 1'b1);
        press_key   = 4'b1010;
        press_hold  = HW'(2);
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done_clr", done, 1'b0);
        wait_done("lat_b2b", 2 * B + 2 * T + 1);
        @(posedge clk); #1;
        chk("b2b_idle", busy, 1'b0);

`ifdef KEYPAD_BOUNCE_EN
        bounce_run(rec0);
        bounce_run(rec1);
        for (int k = 0; k < 32; k++) chk("bounce_repeat", rec1[k], rec0[k]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable model of the 4x4 matrix keypad: the passive end of the row-scan interface. It watches the active-low `keypadRow` lines driven by the keypad scanner and answers on the active-low `keypadCol` lines exactly as a physical key would, for one commanded key held for a commanded time. It replaces the physical keypad on the board for self-test and autoplay, and serves as the keypad model in full-system simulation.

## Interface
Parameters:
- `TICK_CYCLES`, default 50000: `clk` cycles per hold tick (1 ms at 50 MHz).
- `BOUNCE_CYCLES`, default 250000: length of each bounce window in `clk` cycles (5 ms). Must be ≥1.
- `HOLD_W`, default 12: width of `press_hold`.

Ports:
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `press_valid` in 1: press request.
- `press_ready` out 1: emulator can accept a request.
- `press_key` in 4: key code, row = `press_key[3:2]`, column = `press_key[1:0]`; same code space as the scanner's `keypadBuf`.
- `press_hold` in HOLD_W: hold time in ticks; 0 is treated as 1.
- `keypadRow` in 4: row drive from the scanner, active-low.
- `keypadCol` out 4: column sense to the scanner, active-low, idle 4'b1111.
- `busy` out 1: a press is in progress.
- `done` out 1: one-cycle pulse when the key is fully released.

## Operation
- A request is accepted on a cycle with `press_valid && press_ready`. `press_key` and `press_hold` are captured in registers `key_r` and `hold_r` (0 is replaced by 1).
- `press_ready` = (state == IDLE). `busy` = !press_ready.
- Internal `contact` register: the key's switch is closed while it is 1.
- `keypadCol[c]` = 0 iff `contact` && c == `key_r[1:0]` && `keypadRow[key_r[3:2]]` == 0. All other bits are 1.
  - This path is combinational from `keypadRow`, like a real wire.
  - Any other rows driven low have no effect.
  - X or Z on the row drive yields 1.
- FSM states:
  - IDLE: `contact` = 0. On accept, go to BOUNCE_DN and clear the cycle counter.
  - BOUNCE_DN: lasts BOUNCE_CYCLES cycles, then go to HELD with `contact` = 1.
  - HELD: `contact` = 1 for `hold_r` × TICK_CYCLES cycles, then go to BOUNCE_UP.
  - BOUNCE_UP: lasts BOUNCE_CYCLES cycles, then go to IDLE with `contact` = 0 and `done` = 1 for that one cycle.
- Counters:
  - Cycle counter: ceil(log2(max(TICK_CYCLES, BOUNCE_CYCLES)+1)) bits.
  - Tick counter: HOLD_W bits.
  - Both saturate-free. They are reloaded on every state entry and never wrap inside a state.
- `press_valid` outside IDLE is ignored. Nothing is queued.
- Back-to-back presses:
  - A request is accepted in IDLE; `done` and acceptance may coincide.
  - When `done` is high, `press_ready` is also high on that same cycle.
  - A second press therefore has a minimum gap of 1 cycle of IDLE.

## Timing
- Reset values:
  - state IDLE
  - `contact` 0
  - `keypadCol` 4'b1111
  - `press_ready` 1
  - `busy` 0
  - `done` 0
  - counters 0
  - LFSR 16'hACE1
- `rst` mid-press: on the next edge, return to IDLE and open the contact immediately. No `done` pulse is produced.
- Accept at edge N:
  - BOUNCE_DN occupies cycles N+1..N+BOUNCE_CYCLES.
  - `contact` is 1 from edge N+BOUNCE_CYCLES+1.
  - `contact` is 0 and `done` is high after a further `hold_r`×TICK_CYCLES + BOUNCE_CYCLES cycles.
- Total latency from accept to `done` = 2×BOUNCE_CYCLES + `hold_r`×TICK_CYCLES + 1 cycles (exact, with or without bounce).
- `keypadCol` responds to `keypadRow` in the same cycle (0 clk latency). It responds to `contact` one cycle after the state edge.

## Configuration
- `KEYPAD_BOUNCE_EN` defined:
  - In BOUNCE_DN and BOUNCE_UP, `contact` = LFSR[0] each cycle.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advancing every cycle regardless of state.
  - On the last bounce cycle `contact` is forced to its final value: 1 for DN, 0 for UP.
- Not defined: `contact` = 0 throughout BOUNCE_DN and 1 throughout BOUNCE_UP (clean edges). The LFSR is not instantiated. State durations are unchanged.

## Test plan
- Reset, then row drive 4'b0000 -> `keypadCol`=4'b1111, `press_ready`=1, `busy`=0, `done`=0.
- TICK_CYCLES=4, BOUNCE_CYCLES=3. Press key 4'b0110, hold 2, row scan cycling 1110/1101/1011/0111 -> `keypadCol`=4'b1011 only while row=4'b1101 during HELD (8 cycles). `done` on cycle 15 after accept.
- Hold 0, key 4'b1111 -> behaves as hold 1. `keypadCol`=4'b0111 only with row 4'b0111.
- `press_valid` asserted during HELD with a different key -> ignored; original key timing and `done` unchanged.
- `rst` in HELD -> next cycle `keypadCol`=4'b1111, state IDLE, no `done`. A new press is accepted the following cycle.
- `KEYPAD_BOUNCE_EN` defined, row of key held low -> `keypadCol` toggles during bounce windows. It is stable 0 (column bit) for all of HELD and stable 1 after `done`. The same seed gives an identical waveform across runs.
